// File: rtl/pc_gen.sv
// pc_gen: front-end program counter with fetch handshake,
// trap/branch redirect priority and a one-entry pending-redirect buffer.
module pc_gen #(
    parameter int unsigned          PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VEC = '0,
    parameter int unsigned          STEP      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          flow_pc_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                trap_i,
    input  logic [PC_WIDTH-1:0] trap_vec_i,
    input  logic                if_ready_i,
    output logic [PC_WIDTH-1:0] curr_pc_o,
    output logic                pc_valid_o,
    output logic                pend_o
);

    typedef enum logic [1:0] {
        FLOW_WORK    = 2'b00,
        FLOW_STOP    = 2'b01,
        FLOW_REFRESH = 2'b10,
        FLOW_RSVD    = 2'b11
    } flow_e;

    localparam logic [PC_WIDTH-1:0] STEP_V = PC_WIDTH'(STEP);
    localparam logic [PC_WIDTH-1:0] ONE_V  = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] MASK   = ~(STEP_V - ONE_V);

    flow_e               flow;
    logic [PC_WIDTH-1:0] curr_pc;
    logic                pc_valid;
    logic                pend;
    logic [PC_WIDTH-1:0] pend_pc;
    logic                pend_is_trap;
    logic [PC_WIDTH-1:0] trap_tgt;
    logic [PC_WIDTH-1:0] redir_tgt;
    logic                redir_wr;

    assign flow      = flow_e'(flow_pc_i);
    assign trap_tgt  = trap_vec_i & MASK;
    assign redir_tgt = redirect_pc_i & MASK;

    // A buffered trap must never be displaced by a later branch.
    assign redir_wr = redirect_i & (~pend | ~pend_is_trap);

    always_ff @(posedge clk) begin
        if (rst) begin
            curr_pc      <= RESET_VEC;
            pc_valid     <= 1'b0;
            pend         <= 1'b0;
            pend_pc      <= '0;
            pend_is_trap <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            unique case (flow)
                FLOW_WORK: begin
                    if (trap_i) begin
                        curr_pc <= trap_tgt;
                        pend    <= 1'b0;
                    end else if (redirect_i) begin
                        curr_pc <= redir_tgt;
                        pend    <= 1'b0;
                    end else if (pend) begin
                        curr_pc <= pend_pc;
                        pend    <= 1'b0;
                    end else if (if_ready_i && pc_valid) begin
                        curr_pc <= curr_pc + STEP_V;
                    end
                end
                FLOW_STOP: begin
                    if (trap_i) begin
                        pend_pc      <= trap_tgt;
                        pend         <= 1'b1;
                        pend_is_trap <= 1'b1;
                    end else if (redir_wr) begin
                        pend_pc      <= redir_tgt;
                        pend         <= 1'b1;
                        pend_is_trap <= 1'b0;
                    end
                end
                default: begin
                    curr_pc      <= RESET_VEC;
                    pend         <= 1'b0;
                    pend_is_trap <= 1'b0;
                end
            endcase
        end
    end

    assign curr_pc_o  = curr_pc;
    assign pc_valid_o = pc_valid;
    assign pend_o     = pend;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen,
// a 32-bit instance for the main paths and an 8-bit one for wrap.
module tb_pc_gen;

    localparam logic [1:0] W  = 2'b00;
    localparam logic [1:0] S  = 2'b01;
    localparam logic [1:0] RF = 2'b10;
    localparam logic [1:0] RX = 2'b11;

    typedef struct {
        bit          which;
        logic [31:0] pc;
        logic        v;
        logic        p;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rd, tr, rdy;
    logic [1:0]  flow;
    logic [31:0] rpc, tv;
    logic [31:0] pc;
    logic        pv, pd;

    logic        rst8, rd8, tr8, rdy8;
    logic [1:0]  flow8;
    logic [7:0]  rpc8, tv8;
    logic [7:0]  pc8;
    logic        pv8, pd8;

    pc_gen #(
        .PC_WIDTH (32),
        .RESET_VEC(32'h100),
        .STEP     (4)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flow_pc_i    (flow),
        .redirect_i   (rd),
        .redirect_pc_i(rpc),
        .trap_i       (tr),
        .trap_vec_i   (tv),
        .if_ready_i   (rdy),
        .curr_pc_o    (pc),
        .pc_valid_o   (pv),
        .pend_o       (pd)
    );

    pc_gen #(
        .PC_WIDTH (8),
        .RESET_VEC(8'h10),
        .STEP     (4)
    ) u_dut8 (
        .clk          (clk),
        .rst          (rst8),
        .flow_pc_i    (flow8),
        .redirect_i   (rd8),
        .redirect_pc_i(rpc8),
        .trap_i       (tr8),
        .trap_vec_i   (tv8),
        .if_ready_i   (rdy8),
        .curr_pc_o    (pc8),
        .pc_valid_o   (pv8),
        .pend_o       (pd8)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push the expected post-edge state, then compare.
    task automatic cyc(input bit          which,
                       input logic        r,
                       input logic [1:0]  f,
                       input logic        d,
                       input logic [31:0] dpc,
                       input logic        t,
                       input logic [31:0] tpc,
                       input logic        y,
                       input logic [31:0] epc,
                       input logic        ev,
                       input logic        ep,
                       input string       tag);
        exp_t e;
        if (which == 1'b0) begin
            rst = r; flow = f; rd = d; rpc = dpc;
            tr = t; tv = tpc; rdy = y;
        end else begin
            rst8 = r; flow8 = f; rd8 = d; rpc8 = dpc[7:0];
            tr8 = t; tv8 = tpc[7:0]; rdy8 = y;
        end
        e.which = which;
        e.pc    = epc;
        e.v     = ev;
        e.p     = ep;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.which == 1'b0) begin
            check({e.tag, ".pc"}, pc, e.pc);
            check({e.tag, ".vld"}, {31'b0, pv}, {31'b0, e.v});
            check({e.tag, ".pend"}, {31'b0, pd}, {31'b0, e.p});
        end else begin
            check({e.tag, ".pc"}, {24'b0, pc8}, e.pc);
            check({e.tag, ".vld"}, {31'b0, pv8}, {31'b0, e.v});
            check({e.tag, ".pend"}, {31'b0, pd8}, {31'b0, e.p});
        end
    endtask

    // Shorthand for the 32-bit instance with reset low.
    task automatic c32(input logic [1:0]  f,
                       input logic        d,
                       input logic [31:0] dpc,
                       input logic        t,
                       input logic [31:0] tpc,
                       input logic        y,
                       input logic [31:0] epc,
                       input logic        ep,
                       input string       tag);
        cyc(1'b0, 1'b0, f, d, dpc, t, tpc, y, epc, 1'b1, ep, tag);
    endtask

    initial begin
        rst = 1'b1; flow = W; rd = 1'b0; rpc = '0;
        tr = 1'b0; tv = '0; rdy = 1'b1;
        rst8 = 1'b1; flow8 = W; rd8 = 1'b0; rpc8 = '0;
        tr8 = 1'b0; tv8 = '0; rdy8 = 1'b1;

        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, W, 0, 0, 0, 0, 1, 32'h100, 0, 0, "rst");
        c32(W, 0, 0, 0, 0, 1, 32'h100, 0, "boot0");
        c32(W, 0, 0, 0, 0, 1, 32'h104, 0, "boot1");
        c32(W, 0, 0, 0, 0, 1, 32'h108, 0, "boot2");

        c32(W, 1, 32'h20, 0, 0, 0, 32'h20, 0, "bp_load");
        for (int i = 0; i < 4; i++)
            c32(W, 0, 0, 0, 0, 0, 32'h20, 0, "bp_hold");
        c32(W, 0, 0, 0, 0, 1, 32'h24, 0, "bp_go");

        c32(W, 1, 32'h40, 0, 0, 1, 32'h40, 0, "pri_load");
        c32(W, 1, 32'h80, 1, 32'h200, 1, 32'h200, 0, "pri_trap");
        c32(W, 1, 32'h40, 0, 0, 1, 32'h40, 0, "pri_load2");
        c32(W, 1, 32'h83, 0, 0, 1, 32'h80, 0, "pri_align");

        c32(W, 1, 32'h50, 0, 0, 1, 32'h50, 0, "stl_load");
        c32(S, 1, 32'h90, 0, 0, 1, 32'h50, 1, "stl_rd");
        c32(S, 0, 0, 1, 32'h300, 1, 32'h50, 1, "stl_tr");
        c32(S, 1, 32'hA0, 0, 0, 1, 32'h50, 1, "stl_rd2");
        c32(S, 0, 0, 0, 0, 1, 32'h50, 1, "stl_idle");
        c32(W, 0, 0, 0, 0, 1, 32'h300, 0, "stl_apply");
        c32(W, 0, 0, 0, 0, 1, 32'h304, 0, "stl_seq");

        c32(S, 0, 0, 1, 32'h303, 1, 32'h304, 1, "tf_tr");
        c32(S, 1, 32'hB0, 0, 0, 1, 32'h304, 1, "tf_rd");
        c32(W, 0, 0, 0, 0, 0, 32'h300, 0, "tf_apply");

        c32(S, 1, 32'h90, 0, 0, 1, 32'h300, 1, "rr_a");
        c32(S, 1, 32'h94, 0, 0, 1, 32'h300, 1, "rr_b");
        c32(W, 0, 0, 0, 0, 1, 32'h94, 0, "rr_apply");

        c32(S, 1, 32'h70, 0, 0, 1, 32'h94, 1, "sup_buf");
        c32(W, 1, 32'h74, 0, 0, 1, 32'h74, 0, "sup_new");
        c32(W, 0, 0, 0, 0, 1, 32'h78, 0, "sup_seq");

        c32(W, 1, 32'h44, 0, 0, 1, 32'h44, 0, "rf_load");
        c32(S, 1, 32'h60, 0, 0, 1, 32'h44, 1, "rf_buf");
        c32(RF, 0, 0, 1, 32'h200, 1, 32'h100, 0, "rf_10");
        c32(W, 0, 0, 0, 0, 1, 32'h104, 0, "rf_after");
        c32(W, 1, 32'h44, 0, 0, 1, 32'h44, 0, "rx_load");
        c32(S, 1, 32'h60, 0, 0, 1, 32'h44, 1, "rx_buf");
        c32(RX, 0, 0, 1, 32'h200, 1, 32'h100, 0, "rf_11");
        c32(W, 0, 0, 0, 0, 1, 32'h104, 0, "rx_after");

        c32(S, 1, 32'h90, 0, 0, 1, 32'h104, 1, "mr_buf");
        cyc(1'b0, 1'b1, S, 1, 32'h98, 1, 32'h300, 1,
            32'h100, 0, 0, "mr_rst");
        c32(W, 0, 0, 0, 0, 1, 32'h100, 0, "mr_boot0");
        c32(W, 0, 0, 0, 0, 1, 32'h104, 0, "mr_boot1");

        cyc(1'b1, 1'b1, W, 0, 0, 0, 0, 1, 32'h10, 0, 0, "w_rst");
        cyc(1'b1, 1'b0, W, 1, 32'hFC, 0, 0, 1, 32'hFC, 1, 0, "w_load");
        cyc(1'b1, 1'b0, W, 0, 0, 0, 0, 1, 32'h00, 1, 0, "w_wrap");
        cyc(1'b1, 1'b0, W, 0, 0, 0, 0, 1, 32'h04, 1, 0, "w_next");
        cyc(1'b1, 1'b0, S, 0, 0, 1, 32'hEE, 1, 32'h04, 1, 1, "w_buf");
        cyc(1'b1, 1'b0, W, 0, 0, 0, 0, 1, 32'hEC, 1, 0, "w_apply");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the rooth core front end. It is the next generation of the core's PC register.
- Adds a fetch-side valid/ready handshake, trap and branch redirect with fixed priority, and a one-entry pending-redirect buffer. The buffer holds a redirect that arrives while the pipeline is stalled.
- Sits between the flow-control unit, EX/CSR redirect sources and the instruction-fetch stage.

Parameters:
- PC_WIDTH, 32, width of the PC and of every target address.
- RESET_VEC, 0, PC value loaded on reset and on REFRESH.
- STEP, 4, sequential increment in bytes. Must be a power of two, at least 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- flow_pc_i  input  2  flow command: 2'b00 WORK, 2'b01 STOP, 2'b10 REFRESH, 2'b11 reserved and treated as REFRESH.
- redirect_i  input  1  branch/jump redirect request, single-cycle pulse.
- redirect_pc_i  input  PC_WIDTH  redirect target.
- trap_i  input  1  trap/exception/mret redirect request.
- trap_vec_i  input  PC_WIDTH  trap target.
- if_ready_i  input  1  fetch stage accepts curr_pc_o this cycle.
- curr_pc_o  output  PC_WIDTH  current fetch address (registered).
- pc_valid_o  output  1  curr_pc_o is a valid fetch request (registered).
- pend_o  output  1  a redirect is buffered and not yet applied (registered).

Behaviour:
- Reset: one clock is a single clock domain. Reset is synchronous and active-high. The clock port is clk; the reset port is rst.
  - On a rising edge with rst=1: curr_pc_o=RESET_VEC, pc_valid_o=0, pend_o=0, pend_pc=0.
  - rst overrides every other input.
- pc_valid_o becomes 1 on the first rising edge with rst=0 and stays 1 until the next reset.
- Target alignment: every loaded target has its low log2(STEP) bits forced to 0. This applies to redirect_pc_i, trap_vec_i and the buffered target.
- Sequential arithmetic: curr_pc_o + STEP, truncated to PC_WIDTH. Wrap-around is silent (max aligned value -> 0).
- Per-edge priority, highest first:
  1. rst
  2. REFRESH
  3. trap_i
  4. redirect_i
  5. pending entry
  6. sequential advance
  7. hold
- REFRESH (flow 2'b10/2'b11):
  - curr_pc_o <= RESET_VEC; pend_o <= 0.
  - Any trap/redirect in the same cycle is discarded.
- WORK with trap_i or redirect_i:
  - curr_pc_o <= target next edge, independent of if_ready_i. The in-flight fetch is abandoned.
  - If both are asserted, trap_vec_i wins.
  - Any pending entry is cleared (the new request supersedes it).
- WORK, no new request, pend_o=1: curr_pc_o <= pend_pc; pend_o <= 0, independent of if_ready_i.
- WORK, nothing pending: if if_ready_i && pc_valid_o, curr_pc_o <= curr_pc_o + STEP; otherwise hold.
- STOP: curr_pc_o holds. An incoming request is buffered:
  - trap_i: pend_pc <= trap_vec_i, pend_o <= 1, pend_is_trap <= 1. A trap always overwrites the buffer.
  - redirect_i only: written only if pend_o=0 or the buffered entry is a redirect. It never overwrites a buffered trap.
  - trap and redirect together: the trap is buffered.
- A buffered entry survives any number of STOP cycles. It is applied on the first WORK edge, per the rules above.
- Latency: a request issued in WORK is visible on curr_pc_o 1 cycle later. A request issued in STOP is visible 1 cycle after flow returns to WORK.
- No combinational path from any input to any output.

Test Plan:
- Reset/boot: RESET_VEC=32'h100, rst=1 for 3 cycles, then flow=WORK, if_ready=1.
  - -> pc_valid_o=0 during reset.
  - -> curr_pc_o sequence 100, 100, 104, 108 with pc_valid_o=1 from the first edge after reset.
- Backpressure: WORK, pc=0x20, if_ready=0 for 4 cycles, then 1.
  - -> pc stays 0x20 for 4 cycles, then 0x24.
- Redirect priority: WORK, pc=0x40, same cycle redirect_i=1 to 0x80 and trap_i=1 to 0x200.
  - -> next pc=0x200.
  - Repeat with redirect to 0x83 only -> pc=0x80.
- Stall buffering:
  - STOP, pc=0x50. Redirect to 0x90 in cycle 1, trap to 0x300 in cycle 2, redirect to 0xA0 in cycle 3.
  - -> pc holds 0x50; pend_o=1 from cycle 2. Back to WORK -> pc=0x300, pend_o=0.
  - Same with trap first, then redirect -> 0x300 kept.
- Refresh: pend_o=1 with pc=0x44, flow=REFRESH together with trap_i=1.
  - -> pc=RESET_VEC, pend_o=0, trap ignored. flow=2'b11 gives the identical result.
- Wrap: PC_WIDTH=8, STEP=4, pc=0xFC, WORK, ready.
  - -> next pc=0x00.
  - Mid-stream rst=1 with pend_o=1 -> pc=RESET_VEC, pend_o=0, pc_valid_o=0.
